// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use and MDU stall/flush control with a saturating stall counter
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memToRegE,
    input  logic        regWriteE,
    input  logic [4:0]  writeRegE,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        useRsD,
    input  logic        useRtD,
    input  logic        mdStartE,
    input  logic        mdDivE,
    input  logic        mdUseD,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        mdGo,
    output logic        mdBusy,
    output logic        mdDone,
    output logic        errOverlap,
    output logic [31:0] stallCnt
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t           state;
    logic [CNT_W-1:0] count;
    logic             load_use, md_stall, stall;

    assign mdBusy   = state == BUSY;
    assign mdGo     = mdStartE & (state == IDLE);
    assign load_use = memToRegE & regWriteE & (writeRegE != 5'd0) &
                      ((useRsD & (rsD == writeRegE)) | (useRtD & (rtD == writeRegE)));
    assign md_stall = mdUseD & (mdBusy | mdStartE);
    assign stall    = load_use | md_stall;
    assign stallF   = stall;
    assign stallD   = stall;
    assign flushE   = stall;

    // MDU occupancy FSM: a start loads the countdown, the last busy cycle arms the done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            mdDone     <= 1'b0;
            errOverlap <= 1'b0;
        end else begin
            mdDone <= 1'b0;
            case (state)
                IDLE: if (mdStartE) begin
                    count <= mdDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state <= BUSY;
                end
                BUSY: begin
                    if (mdStartE) errOverlap <= 1'b1;
                    if (count == CNT_W'(1)) begin
                        state  <= IDLE;
                        count  <= '0;
                        mdDone <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall-cycle performance counter, pinned at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stallCnt <= '0;
        else if (stall && stallCnt != 32'hFFFF_FFFF) stallCnt <= stallCnt + 32'd1;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle MDU and reset sequences
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        memToRegE = 0, regWriteE = 0, useRsD = 0, useRtD = 0;
    logic        mdStartE = 0, mdDivE = 0, mdUseD = 0;
    logic [4:0]  writeRegE = 0, rsD = 0, rtD = 0;
    logic        stallF, stallD, flushE, mdGo, mdBusy, mdDone, errOverlap;
    logic [31:0] stallCnt;
    int          tests = 0, failed = 0;

    typedef struct {
        logic       mem, rw;
        logic [4:0] wr, rs, rt;
        logic       urs, urt, mdu;
        logic       exp;
    } vec_t;
    vec_t vecs[10];

    pipe_hazard_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .memToRegE(memToRegE), .regWriteE(regWriteE), .writeRegE(writeRegE),
        .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .mdStartE(mdStartE), .mdDivE(mdDivE), .mdUseD(mdUseD),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mdGo(mdGo), .mdBusy(mdBusy), .mdDone(mdDone),
        .errOverlap(errOverlap), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        memToRegE = 0; regWriteE = 0; writeRegE = 0; rsD = 0; rtD = 0;
        useRsD = 0; useRtD = 0; mdStartE = 0; mdDivE = 0; mdUseD = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        #1 reset_n = 1;
    endtask

    task automatic set_lw8();
        memToRegE = 1; regWriteE = 1; writeRegE = 5'd8; rsD = 5'd8; useRsD = 1;
    endtask

    task automatic md_seq(input logic div, input int ovl, output int busy_n, output int done_n,
                          output int done_at, output int stall_n, output int go_n);
        busy_n = 0; done_n = 0; done_at = -1; stall_n = 0; go_n = 0;
        mdDivE = div;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mdStartE = (i == 0) || (i == ovl);
            #1;
            if (mdBusy) busy_n++;
            if (mdDone) begin done_n++; done_at = i; end
            if (stallF) stall_n++;
            if (mdGo) go_n++;
        end
        @(negedge clk);
        mdStartE = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, da, s, g, bad_busy, bad_done;
        vecs[0] = '{1, 1, 5'd8,  5'd8,  5'd0,  1, 0, 0, 1};
        vecs[1] = '{1, 1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0};
        vecs[2] = '{1, 1, 5'd12, 5'd3,  5'd12, 0, 1, 0, 1};
        vecs[3] = '{1, 1, 5'd12, 5'd3,  5'd12, 1, 0, 0, 0};
        vecs[4] = '{0, 1, 5'd8,  5'd8,  5'd8,  1, 1, 0, 0};
        vecs[5] = '{1, 0, 5'd8,  5'd8,  5'd8,  1, 1, 0, 0};
        vecs[6] = '{1, 1, 5'd8,  5'd9,  5'd10, 1, 1, 0, 0};
        vecs[7] = '{1, 1, 5'd5,  5'd5,  5'd5,  0, 1, 0, 1};
        vecs[8] = '{0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0};
        vecs[9] = '{1, 1, 5'd31, 5'd1,  5'd31, 1, 1, 0, 1};

        #12;
        check("reset_busy", mdBusy, 0);
        check("reset_done", mdDone, 0);
        check("reset_err", errOverlap, 0);
        check("reset_cnt", stallCnt, 0);
        check("reset_stall", {stallF, stallD, flushE}, 0);
        reset_n = 1;

        foreach (vecs[k]) begin
            @(negedge clk);
            memToRegE = vecs[k].mem; regWriteE = vecs[k].rw; writeRegE = vecs[k].wr;
            rsD = vecs[k].rs; rtD = vecs[k].rt; useRsD = vecs[k].urs; useRtD = vecs[k].urt;
            mdUseD = vecs[k].mdu;
            #1;
            check($sformatf("vec%0d_stall", k), {stallF, stallD, flushE}, {3{vecs[k].exp}});
            #1 clr_inputs();
        end
        check("vec_cnt_idle", stallCnt, 0);

        @(negedge clk);
        set_lw8();
        #1 check("lu_stall", stallF, 1);
        @(negedge clk);
        memToRegE = 0; regWriteE = 0; writeRegE = 0;
        #1 check("lu_released", stallF, 0);
        check("lu_cnt", stallCnt, 1);
        set_lw8();
        writeRegE = 0; rsD = 0;
        #1 check("lu_r0_stall", stallF, 0);
        @(negedge clk);
        check("lu_r0_cnt", stallCnt, 1);
        clr_inputs();

        do_reset();
        md_seq(0, -1, b, d, da, s, g);
        check("mul_go", g, 1);
        check("mul_busy", b, 5);
        check("mul_done_n", d, 1);
        check("mul_done_at", da, 6);
        check("mul_nostall", stallCnt, 0);

        do_reset();
        mdUseD = 1;
        md_seq(1, -1, b, d, da, s, g);
        check("div_busy", b, 10);
        check("div_done_at", da, 11);
        check("div_stall", s, 11);
        check("div_cnt", stallCnt, 11);
        check("div_err", errOverlap, 0);

        md_seq(0, 3, b, d, da, s, g);
        check("ovl_go", g, 1);
        check("ovl_busy", b, 5);
        check("ovl_done_at", da, 6);
        check("ovl_err", errOverlap, 1);
        repeat (3) @(negedge clk);
        check("ovl_err_sticky", errOverlap, 1);

        mdDivE = 1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            mdStartE = (i == 0);
        end
        #1 check("rst_pre_busy", mdBusy, 1);
        #1 reset_n = 0;
        #1;
        check("rst_busy", mdBusy, 0);
        check("rst_err", errOverlap, 0);
        check("rst_cnt", stallCnt, 0);
        check("rst_done", mdDone, 0);
        reset_n = 1;
        mdUseD = 0;
        bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (mdBusy) bad_busy++;
            if (mdDone) bad_done++;
        end
        check("rst_no_busy", bad_busy, 0);
        check("rst_no_done", bad_done, 0);

        do_reset();
        @(negedge clk);
        force dut.stallCnt = 32'hFFFF_FFFD;
        #1 release dut.stallCnt;
        #1 check("sat_preload", stallCnt, 32'hFFFF_FFFD);
        set_lw8();
        @(negedge clk) check("sat_fe", stallCnt, 32'hFFFF_FFFE);
        @(negedge clk) check("sat_ff", stallCnt, 32'hFFFF_FFFF);
        @(negedge clk) check("sat_hold1", stallCnt, 32'hFFFF_FFFF);
        @(negedge clk) check("sat_hold2", stallCnt, 32'hFFFF_FFFF);
        clr_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
